// File: rtl/midi_pkg.sv
// Shared MIDI decoder definitions: status types, byte thresholds, FSM states
// and the stored-status record.
package midi_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned DATA_W = 7;
    localparam int unsigned LEN_W  = 2;

    localparam logic [NIB_W-1:0] MIDI_NOTE_OFF   = 4'h8;
    localparam logic [NIB_W-1:0] MIDI_NOTE_ON    = 4'h9;
    localparam logic [NIB_W-1:0] MIDI_PROG_CHG   = 4'hC;
    localparam logic [NIB_W-1:0] MIDI_CHAN_PRESS = 4'hD;
    localparam logic [NIB_W-1:0] MIDI_SYSTEM     = 4'hF;

    localparam logic [BYTE_W-1:0] MIDI_REALTIME_MIN = 8'hF8;
    localparam logic [BYTE_W-1:0] MIDI_RESET_NOTE   = 8'd69;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA1 = 3'd1,
        ST_DATA2 = 3'd2,
        ST_SKIP1 = 3'd3,
        ST_SKIP2 = 3'd4
    } midi_state_e;

    // Stored running status; len is the data-byte count of the message type
    typedef struct packed {
        logic              valid;
        logic [NIB_W-1:0]  mtype;
        logic [NIB_W-1:0]  chan;
        logic [LEN_W-1:0]  len;
    } midi_status_t;

    function automatic logic [LEN_W-1:0] midi_data_len(input logic [NIB_W-1:0] mtype);
        if ((mtype == MIDI_PROG_CHG) || (mtype == MIDI_CHAN_PRESS)) begin
            return LEN_W'(1);
        end
        return LEN_W'(2);
    endfunction

endpackage

// File: rtl/midi_byte_classify.sv
// Combinational classifier splitting a MIDI byte into its class flags and
// status fields.
module midi_byte_classify
    import midi_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_i,
    output logic              is_status_c,
    output logic              is_realtime_c,
    output logic              is_syscommon_c,
    output logic [NIB_W-1:0]  type_c,
    output logic [NIB_W-1:0]  chan_c,
    output logic [LEN_W-1:0]  data_len_c
);

    always_comb begin
        is_status_c    = byte_i[BYTE_W-1];
        is_realtime_c  = (byte_i >= MIDI_REALTIME_MIN);
        is_syscommon_c = (byte_i[BYTE_W-1 -: NIB_W] == MIDI_SYSTEM) && !is_realtime_c;
        type_c         = byte_i[BYTE_W-1 -: NIB_W];
        chan_c         = byte_i[NIB_W-1:0];
        data_len_c     = midi_data_len(byte_i[BYTE_W-1 -: NIB_W]);
    end

endmodule

// File: rtl/midi_note_decoder.sv
// Monophonic last-note-priority MIDI decoder producing NOTE/VELOCITY/GATE.
// Optional running status is enabled with `define MIDI_RUNNING_STATUS_EN.
module midi_note_decoder
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [BYTE_W-1:0] BYTE_IN,
    input  logic              BYTE_VALID,
    output logic [BYTE_W-1:0] NOTE,
    output logic [DATA_W-1:0] VELOCITY,
    output logic              GATE,
    output logic              NOTE_STROBE
);

`ifdef MIDI_RUNNING_STATUS_EN
    localparam bit RunStatusEn = 1'b1;
`else
    localparam bit RunStatusEn = 1'b0;
`endif

    logic              is_status_c;
    logic              is_realtime_c;
    logic              is_syscommon_c;
    logic [NIB_W-1:0]  type_c;
    logic [NIB_W-1:0]  chan_c;
    logic [LEN_W-1:0]  data_len_c;

    midi_state_e       state_q, state_d;
    midi_status_t      status_q, status_d;
    logic [DATA_W-1:0] cand_q, cand_d;
    logic [DATA_W-1:0] note_q, note_d;
    logic [DATA_W-1:0] vel_q, vel_d;
    logic              gate_q, gate_d;
    logic              strobe_q, strobe_d;
    logic              msg_done_c;
    logic [DATA_W-1:0] data_c;

    midi_byte_classify u_classify (
        .byte_i         (BYTE_IN),
        .is_status_c    (is_status_c),
        .is_realtime_c  (is_realtime_c),
        .is_syscommon_c (is_syscommon_c),
        .type_c         (type_c),
        .chan_c         (chan_c),
        .data_len_c     (data_len_c)
    );

    function automatic logic is_ours(input logic [NIB_W-1:0] mtype, input logic [NIB_W-1:0] chan);
        return (chan == CHANNEL) && ((mtype == MIDI_NOTE_ON) || (mtype == MIDI_NOTE_OFF));
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            status_q <= '0;
            cand_q   <= '0;
            note_q   <= DATA_W'(MIDI_RESET_NOTE);
            vel_q    <= '0;
            gate_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cand_q   <= cand_d;
            note_q   <= note_d;
            vel_q    <= vel_d;
            gate_q   <= gate_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        cand_d     = cand_q;
        note_d     = note_q;
        vel_d      = vel_q;
        gate_d     = gate_q;
        strobe_d   = 1'b0;
        msg_done_c = 1'b0;
        data_c     = BYTE_IN[DATA_W-1:0];

        // Realtime bytes fall through untouched, even mid-message
        if (BYTE_VALID && !is_realtime_c) begin
            if (is_syscommon_c) begin
                status_d = '0;
                state_d  = ST_IDLE;
            end else if (is_status_c) begin
                status_d.valid = 1'b1;
                status_d.mtype = type_c;
                status_d.chan  = chan_c;
                status_d.len   = data_len_c;
                state_d        = is_ours(type_c, chan_c) ? ST_DATA1 : ST_SKIP1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (RunStatusEn && status_q.valid) begin
                            if (is_ours(status_q.mtype, status_q.chan)) begin
                                cand_d  = data_c;
                                state_d = ST_DATA2;
                            end else if (status_q.len == LEN_W'(2)) begin
                                state_d = ST_SKIP2;
                            end else begin
                                state_d    = ST_IDLE;
                                msg_done_c = 1'b1;
                            end
                        end
                    end
                    ST_DATA1: begin
                        cand_d  = data_c;
                        state_d = ST_DATA2;
                    end
                    ST_DATA2: begin
                        // Note-on with velocity wins; otherwise only a matching note releases
                        if ((status_q.mtype == MIDI_NOTE_ON) && (data_c != '0)) begin
                            note_d   = cand_q;
                            vel_d    = data_c;
                            gate_d   = 1'b1;
                            strobe_d = 1'b1;
                        end else if (cand_q == note_q) begin
                            gate_d   = 1'b0;
                            strobe_d = 1'b1;
                        end
                        state_d    = ST_IDLE;
                        msg_done_c = 1'b1;
                    end
                    ST_SKIP1: begin
                        if (status_q.len == LEN_W'(2)) begin
                            state_d = ST_SKIP2;
                        end else begin
                            state_d    = ST_IDLE;
                            msg_done_c = 1'b1;
                        end
                    end
                    ST_SKIP2: begin
                        state_d    = ST_IDLE;
                        msg_done_c = 1'b1;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
                if (msg_done_c && !RunStatusEn) begin
                    status_d.valid = 1'b0;
                end
            end
        end
    end

    assign NOTE        = {1'b0, note_q};
    assign VELOCITY    = vel_q;
    assign GATE        = gate_q;
    assign NOTE_STROBE = strobe_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Scoreboard bench for midi_note_decoder: a message-level reference model
// predicts every strobe; a negedge monitor checks strobes and held outputs.
module tb_midi_note_decoder;

`ifdef MIDI_RUNNING_STATUS_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] BYTE_IN = 8'h00;
    logic       BYTE_VALID = 1'b0;
    logic [7:0] NOTE;
    logic [6:0] VELOCITY;
    logic       GATE;
    logic       NOTE_STROBE;

    always #5 CLK = ~CLK;

    midi_note_decoder #(.CHANNEL(4'd0)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BYTE_IN     (BYTE_IN),
        .BYTE_VALID  (BYTE_VALID),
        .NOTE        (NOTE),
        .VELOCITY    (VELOCITY),
        .GATE        (GATE),
        .NOTE_STROBE (NOTE_STROBE)
    );

    typedef struct packed {
        logic [7:0] note;
        logic [6:0] vel;
        logic       gate;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    bit   mon_en  = 1'b1;

    // Reference model: collects a message's data bytes, then applies note rules
    bit         m_sv;
    bit         m_active;
    logic [7:0] m_st;
    int         m_need;
    int         m_cnt;
    logic [7:0] m_d [2];
    logic [7:0] m_note;
    logic [6:0] m_vel;
    bit         m_gate;

    task automatic model_reset();
        m_sv = 0; m_active = 0; m_cnt = 0; m_need = 2;
        m_note = 8'd69; m_vel = 7'd0; m_gate = 0;
    endtask

    task automatic model_complete();
        if (m_st[3:0] == 4'd0 && (m_st[7:4] == 4'h8 || m_st[7:4] == 4'h9)) begin
            if (m_st[7:4] == 4'h9 && m_d[1] != 8'd0) begin
                m_note = m_d[0]; m_vel = m_d[1][6:0]; m_gate = 1;
                exp_q.push_back('{note: m_note, vel: m_vel, gate: m_gate});
            end else if (m_d[0] == m_note) begin
                m_gate = 0;
                exp_q.push_back('{note: m_note, vel: m_vel, gate: m_gate});
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            m_sv = 0; m_active = 0;
            return;
        end
        if (b[7]) begin
            m_st = b; m_sv = 1; m_active = 1; m_cnt = 0;
            m_need = (b[7:4] == 4'hC || b[7:4] == 4'hD) ? 1 : 2;
            return;
        end
        if (!m_active) begin
            if (RS && m_sv) begin
                m_active = 1; m_cnt = 0;
            end else begin
                return;
            end
        end
        m_d[m_cnt] = b;
        m_cnt++;
        if (m_cnt == m_need) begin
            model_complete();
            m_active = 0;
            if (!RS) m_sv = 0;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit rst = 1'b0);
        @(posedge CLK); #1;
        BYTE_IN = b; BYTE_VALID = 1'b1; RESET = rst;
        if (rst) model_reset();
        else model_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            BYTE_VALID = 1'b0; RESET = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1'b1; BYTE_VALID = 1'b0;
        model_reset();
        idle(1);
    endtask

    task automatic send_seq(input logic [7:0] s [$]);
        foreach (s[i]) send(s[i]);
        idle(2);
    endtask

    task automatic check_out(input string name, input logic [7:0] n, input logic [6:0] v, input logic g);
        vectors++;
        if (NOTE !== n || VELOCITY !== v || GATE !== g) begin
            errors++;
            $display("FAIL %s: got note=%0d vel=%0d gate=%0b, want note=%0d vel=%0d gate=%0b",
                     name, NOTE, VELOCITY, GATE, n, v, g);
        end
    endtask

    // Monitor: reset values, predicted strobes, and stable outputs otherwise
    logic rst_d = 1'b1;
    exp_t cur;
    always @(posedge CLK) rst_d <= RESET;

    always @(negedge CLK) begin
        if (mon_en) begin
            vectors++;
            if (rst_d) begin
                cur = '{note: 8'd69, vel: 7'd0, gate: 1'b0};
                if (NOTE !== 8'd69 || VELOCITY !== 7'd0 || GATE !== 1'b0 || NOTE_STROBE !== 1'b0) begin
                    errors++;
                    $display("FAIL reset: got note=%0d vel=%0d gate=%0b strobe=%0b, want 69 0 0 0",
                             NOTE, VELOCITY, GATE, NOTE_STROBE);
                end
            end else if (NOTE_STROBE === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe: got unexpected strobe note=%0d vel=%0d gate=%0b, want no strobe",
                             NOTE, VELOCITY, GATE);
                end else begin
                    cur = exp_q.pop_front();
                    if (NOTE !== cur.note || VELOCITY !== cur.vel || GATE !== cur.gate) begin
                        errors++;
                        $display("FAIL update: got note=%0d vel=%0d gate=%0b, want note=%0d vel=%0d gate=%0b",
                                 NOTE, VELOCITY, GATE, cur.note, cur.vel, cur.gate);
                    end
                end
            end else if (NOTE !== cur.note || VELOCITY !== cur.vel || GATE !== cur.gate || NOTE_STROBE !== 1'b0) begin
                errors++;
                $display("FAIL hold: got note=%0d vel=%0d gate=%0b strobe=%0b, want note=%0d vel=%0d gate=%0b strobe=0",
                         NOTE, VELOCITY, GATE, NOTE_STROBE, cur.note, cur.vel, cur.gate);
            end
        end
    end

    initial begin
        model_reset();
        RESET = 1'b1;
        idle(1);
        idle(3);
        check_out("reset_idle", 8'd69, 7'd0, 1'b0);

        send_seq('{8'h90, 8'h39, 8'h64});
        check_out("note_on_57", 8'd57, 7'd100, 1'b1);

        send_seq('{8'h90, 8'h51, 8'h40, 8'h80, 8'h39, 8'h00});
        check_out("last_note_priority", 8'd81, 7'd64, 1'b1);
        send_seq('{8'h90, 8'h51, 8'h00});
        check_out("vel0_release", 8'd81, 7'd64, 1'b0);

        send_seq('{8'h91, 8'h45, 8'h7F, 8'hC0, 8'h05});
        check_out("other_channel", 8'd81, 7'd64, 1'b0);
        send_seq('{8'h90, 8'h45, 8'h10});
        check_out("accept_after_skip", 8'd69, 7'd16, 1'b1);

        send_seq('{8'h90, 8'h45, 8'hF8, 8'h20});
        check_out("realtime_mid_msg", 8'd69, 7'd32, 1'b1);
        send_seq('{8'h90, 8'h45, 8'h80, 8'h45, 8'h00});
        check_out("status_abort", 8'd69, 7'd32, 1'b0);

        do_reset();
        send_seq('{8'h90, 8'h39, 8'h40, 8'h51, 8'h40});
        if (RS) check_out("running_status", 8'd81, 7'd64, 1'b1);
        else    check_out("no_running_status", 8'd57, 7'd64, 1'b1);

        send_seq('{8'h90, 8'h45});
        do_reset();
        send_seq('{8'h20});
        check_out("reset_mid_msg", 8'd69, 7'd0, 1'b0);
        send(8'h90); send(8'h45); send(8'h20, 1'b1);
        idle(2);
        check_out("reset_priority", 8'd69, 7'd0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [7:0] b;
            logic [3:0] t;
            logic [7:0] notes [4];
            notes = '{8'd57, 8'd69, 8'd81, 8'd60};
            r = int'($urandom_range(0, 99));
            if (r < 6) begin
                b = 8'hF8 + 8'($urandom_range(0, 7));
            end else if (r < 9) begin
                b = 8'hF0 + 8'($urandom_range(0, 7));
            end else if (r < 35) begin
                case ($urandom_range(0, 7))
                    0: t = 4'h8; 1, 2: t = 4'h9; 3: t = 4'hA;
                    4: t = 4'hB; 5: t = 4'hC; 6: t = 4'hD; default: t = 4'hE;
                endcase
                b = {t, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0};
            end else begin
                r = int'($urandom_range(0, 9));
                if (r < 5)      b = notes[$urandom_range(0, 3)];
                else if (r < 7) b = 8'd0;
                else            b = 8'($urandom_range(0, 127));
            end
            send(b);
            if ($urandom_range(0, 4) == 0) idle(1);
            if ($urandom_range(0, 199) == 0) do_reset();
        end
        idle(4);

        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending updates, want 0", exp_q.size());
        end
        check_out("final_state", m_note, m_vel, m_gate);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
